ex_stage: RTL and testbench

Execute stage of the five-stage MIPS R2000 pipeline, directly downstream of the decode stage `ID`. It consumes ID's registered outputs (`ex`/`m`/`wb` control, `rs`/`rt`/`rd`, `imm`, `data_1`/`data_2`) and resolves operand forwarding from the MEM and WB stages. It performs the ALU operation, or runs an iterative 32-cycle HI/LO multiplier with interlock, and drives the EX/MEM pipeline register.

---
 rtl/ex_stage.sv | 201 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS R2000 execute stage: forwarding, ALU, iterative HI/LO multiplier, EX/MEM register
// Multiply runs one shift-add step per cycle; dependants of HI/LO or a second multiply stall until done.
module ex_stage #(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  ex,
   input  logic [2:0]  m,
   input  logic [1:0]  wb,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   input  logic [31:0] data_1,
   input  logic [31:0] data_2,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_alu_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] write_data_reg,
   output logic        stall_req,
   output logic [2:0]  m_out,
   output logic [1:0]  wb_out,
   output logic [31:0] alu_result,
   output logic [31:0] store_data,
   output logic [4:0]  dest_reg,
   output logic        ovf_exception
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state, state_nxt;
   logic [4:0]  count, count_nxt;
   logic [31:0] mplier, mplier_nxt;
   logic [63:0] mcand, mcand_nxt, acc, acc_nxt, acc_add, product;
   logic        neg, neg_nxt;
   logic [31:0] hi, lo, hi_nxt, lo_nxt;

   logic [3:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] op_a, op_b_raw, imm_x, op_b, sum, diff, result, a_abs, b_abs;
   logic        ovf, is_rtype, is_mult, is_multu, is_mul, is_mfhi, is_mflo;

   assign alu_op = ex[4:1];
   assign funct  = imm[5:0];
   assign shamt  = imm[10:6];

   // MEM result is younger than WB, so it wins when both name the same source
   always_comb begin
      if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs)      op_a = mem_alu_result;
      else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs)    op_a = write_data_reg;
      else                                                       op_a = data_1;
      if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rt)      op_b_raw = mem_alu_result;
      else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rt)    op_b_raw = write_data_reg;
      else                                                       op_b_raw = data_2;
   end

   always_comb begin
      case (alu_op)
         4'b0000: imm_x = {{16{imm[15]}}, imm[15:0]};
         4'b0011: imm_x = {16'd0, imm[15:0]};
         default: imm_x = imm;
      endcase
   end

   assign op_b     = ex[0] ? imm_x : op_b_raw;
   assign sum      = op_a + op_b;
   assign diff     = op_a - op_b;
   assign is_rtype = (alu_op == 4'b0010);
   assign is_mult  = is_rtype && funct == 6'b011000;
   assign is_multu = is_rtype && funct == 6'b011001;
   assign is_mul   = is_mult || is_multu;
   assign is_mfhi  = is_rtype && funct == 6'b010000;
   assign is_mflo  = is_rtype && funct == 6'b010010;

   always_comb begin
      result = 32'd0;
      ovf    = 1'b0;
      case (alu_op)
         4'b0000: result = sum;
         4'b0001: result = diff;
         4'b0011: result = op_a & op_b;
         4'b0010: begin
            case (funct)
               6'b100000: begin
                  result = sum;
                  ovf    = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
               end
               6'b100010: begin
                  result = diff;
                  ovf    = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
               end
               6'b100001: result = sum;
               6'b100011: result = diff;
               6'b100100: result = op_a & op_b;
               6'b100101: result = op_a | op_b;
               6'b100110: result = op_a ^ op_b;
               6'b100111: result = ~(op_a | op_b);
               6'b101010: result = {31'd0, $signed(op_a) < $signed(op_b)};
               6'b101011: result = {31'd0, op_a < op_b};
               6'b000000: result = op_b_raw << shamt;
               6'b000010: result = op_b_raw >> shamt;
               6'b000011: result = $signed(op_b_raw) >>> shamt;
               6'b010000: result = hi;
               6'b010010: result = lo;
               default:   result = 32'd0;
            endcase
         end
         default: result = 32'd0;
      endcase
   end

   assign stall_req = rst_n && (state == BUSY) && (is_mul || is_mfhi || is_mflo);

   assign a_abs   = (is_mult && op_a[31]) ? -op_a : op_a;
   assign b_abs   = (is_mult && op_b[31]) ? -op_b : op_b;
   assign acc_add = acc + (mplier[0] ? mcand : 64'd0);
   assign product = neg ? -acc_add : acc_add;

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      mplier_nxt = mplier;
      mcand_nxt  = mcand;
      acc_nxt    = acc;
      neg_nxt    = neg;
      hi_nxt     = hi;
      lo_nxt     = lo;
      case (state)
         IDLE: begin
            if (is_mul) begin
               state_nxt  = BUSY;
               count_nxt  = 5'd0;
               mplier_nxt = b_abs;
               mcand_nxt  = {32'd0, a_abs};
               acc_nxt    = 64'd0;
               neg_nxt    = is_mult && (op_a[31] ^ op_b[31]);
            end
         end
         BUSY: begin
            acc_nxt    = acc_add;
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
            count_nxt  = count + 5'd1;
            if (count == 5'(MUL_CYCLES - 1)) begin
               hi_nxt    = product[63:32];
               lo_nxt    = product[31:0];
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         count         <= 5'd0;
         mplier        <= 32'd0;
         mcand         <= 64'd0;
         acc           <= 64'd0;
         neg           <= 1'b0;
         hi            <= 32'd0;
         lo            <= 32'd0;
         m_out         <= 3'd0;
         wb_out        <= 2'd0;
         alu_result    <= 32'd0;
         store_data    <= 32'd0;
         dest_reg      <= 5'd0;
         ovf_exception <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         mplier <= mplier_nxt;
         mcand  <= mcand_nxt;
         acc    <= acc_nxt;
         neg    <= neg_nxt;
         hi     <= hi_nxt;
         lo     <= lo_nxt;
         if (stall_req) begin
            m_out         <= 3'd0;
            wb_out        <= 2'd0;
            alu_result    <= 32'd0;
            store_data    <= 32'd0;
            dest_reg      <= 5'd0;
            ovf_exception <= 1'b0;
         end else begin
            m_out         <= m;
            wb_out        <= {wb[1] & ~ovf & ~is_mul, wb[0]};
            alu_result    <= result;
            store_data    <= op_b_raw;
            dest_reg      <= ex[5] ? rd : rt;
            ovf_exception <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed and randomized self-checking bench for ex_stage
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  ex;
   logic [2:0]  m;
   logic [1:0]  wb;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm, data_1, data_2;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_alu_result, write_data_reg;
   logic        stall_req;
   logic [2:0]  m_out;
   logic [1:0]  wb_out;
   logic [31:0] alu_result, store_data;
   logic [4:0]  dest_reg;
   logic        ovf_exception;

   int errors = 0;
   int checks = 0;

   ex_stage #(.MUL_CYCLES(32)) dut (
      .clk(clk), .rst_n(rst_n), .ex(ex), .m(m), .wb(wb), .rs(rs), .rt(rt), .rd(rd),
      .imm(imm), .data_1(data_1), .data_2(data_2),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .write_data_reg(write_data_reg),
      .stall_req(stall_req), .m_out(m_out), .wb_out(wb_out), .alu_result(alu_result),
      .store_data(store_data), .dest_reg(dest_reg), .ovf_exception(ovf_exception)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model state: cycles of multiply left, architectural and pending HI/LO
   int          mul_left = 0;
   logic [31:0] mhi = 0, mlo = 0, phi = 0, plo = 0, nhi, nlo;
   logic        start_mul;
   logic        e_stall, e_ovf, obs_stall;
   logic [2:0]  e_m;
   logic [1:0]  e_wb;
   logic [31:0] e_res, e_sd;
   logic [4:0]  e_dest;

   function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
      if (mem_reg_write && mem_rd != 0 && mem_rd == src) return mem_alu_result;
      if (wb_reg_write && wb_rd != 0 && wb_rd == src) return write_data_reg;
      return rf;
   endfunction

   task automatic model_eval();
      logic [31:0] a, braw, bop, res;
      logic [5:0]  fn;
      logic [4:0]  sh;
      longint      s, lim, pa, pb;
      logic [63:0] prod, ua, ub;
      logic        ovf, rtype, ismul, usesmd;
      lim = 64'sd2147483648;
      a = fwd(rs, data_1);
      braw = fwd(rt, data_2);
      if (ex[4:1] == 4'd0)      bop = ex[0] ? {{16{imm[15]}}, imm[15:0]} : braw;
      else if (ex[4:1] == 4'd3) bop = ex[0] ? {16'd0, imm[15:0]} : braw;
      else                      bop = ex[0] ? imm : braw;
      fn = imm[5:0];
      sh = imm[10:6];
      rtype = (ex[4:1] == 4'd2);
      ismul = rtype && (fn == 6'd24 || fn == 6'd25);
      usesmd = ismul || (rtype && (fn == 6'd16 || fn == 6'd18));
      res = 0;
      ovf = 0;
      prod = 0;
      case (ex[4:1])
         4'd0: res = a + bop;
         4'd1: res = a - bop;
         4'd3: res = a & bop;
         4'd2: begin
            case (fn)
               6'd32: begin
                  s = longint'($signed(a)) + longint'($signed(bop));
                  res = a + bop;
                  ovf = (s >= lim) || (s < -lim);
               end
               6'd34: begin
                  s = longint'($signed(a)) - longint'($signed(bop));
                  res = a - bop;
                  ovf = (s >= lim) || (s < -lim);
               end
               6'd33: res = a + bop;
               6'd35: res = a - bop;
               6'd36: res = a & bop;
               6'd37: res = a | bop;
               6'd38: res = a ^ bop;
               6'd39: res = ~(a | bop);
               6'd42: res = ($signed(a) < $signed(bop)) ? 1 : 0;
               6'd43: res = (a < bop) ? 1 : 0;
               6'd0:  res = braw << sh;
               6'd2:  res = braw >> sh;
               6'd3:  res = $signed(braw) >>> sh;
               6'd16: res = mhi;
               6'd18: res = mlo;
               6'd24: begin
                  pa = longint'($signed(a));
                  pb = longint'($signed(bop));
                  prod = pa * pb;
               end
               6'd25: begin
                  ua = {32'd0, a};
                  ub = {32'd0, bop};
                  prod = ua * ub;
               end
               default: res = 0;
            endcase
         end
         default: res = 0;
      endcase
      e_stall = rst_n && (mul_left > 0) && usesmd;
      start_mul = rst_n && !e_stall && ismul;
      nhi = prod[63:32];
      nlo = prod[31:0];
      if (!rst_n || e_stall) begin
         e_m = 0; e_wb = 0; e_res = 0; e_sd = 0; e_dest = 0; e_ovf = 0;
      end else begin
         e_m = m;
         e_wb = {wb[1] && !ovf && !ismul, wb[0]};
         e_res = res;
         e_sd = braw;
         e_dest = ex[5] ? rd : rt;
         e_ovf = ovf;
      end
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         mul_left = 0; mhi = 0; mlo = 0;
      end else begin
         if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
               mhi = phi; mlo = plo;
            end
         end
         if (start_mul) begin
            mul_left = 32; phi = nhi; plo = nlo;
         end
      end
   endtask

   task automatic cycle();
      #1;
      model_eval();
      obs_stall = stall_req;
      check("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
      @(posedge clk);
      model_edge();
      #1;
      check("m_out", {29'd0, m_out}, {29'd0, e_m});
      check("wb_out", {30'd0, wb_out}, {30'd0, e_wb});
      check("alu_result", alu_result, e_res);
      check("store_data", store_data, e_sd);
      check("dest_reg", {27'd0, dest_reg}, {27'd0, e_dest});
      check("ovf_exception", {31'd0, ovf_exception}, {31'd0, e_ovf});
   endtask

   task automatic clr_fwd();
      mem_reg_write = 0; mem_rd = 0; mem_alu_result = 0;
      wb_reg_write = 0; wb_rd = 0; write_data_reg = 0;
   endtask

   task automatic set_r(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh,
                        input logic [31:0] d1, input logic [31:0] d2);
      ex = 6'b100100; m = 0; wb = 2'b10;
      rs = s; rt = t; rd = d;
      imm = {16'd0, d, sh, fn};
      data_1 = d1; data_2 = d2;
   endtask

   task automatic set_i(input logic [5:0] exv, input logic [15:0] iv, input logic [31:0] d1);
      ex = exv; m = 0; wb = 2'b10;
      rs = 5'd1; rt = 5'd2; rd = 5'd0;
      imm = {16'd0, iv};
      data_1 = d1; data_2 = 0;
   endtask

   task automatic nop();
      ex = 0; m = 0; wb = 0; rs = 0; rt = 0; rd = 0; imm = 0; data_1 = 0; data_2 = 0;
   endtask

   initial begin
      int stalls;
      logic [5:0] functs [18];
      functs = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                 6'd43, 6'd0, 6'd2, 6'd3, 6'd16, 6'd18, 6'd24, 6'd25, 6'd50};
      rst_n = 0;
      nop();
      clr_fwd();
      cycle();
      cycle();
      check("reset_alu_result", alu_result, 32'd0);
      rst_n = 1;

      // forwarding priority: A from MEM, B from WB
      set_r(6'd32, 5'd3, 5'd4, 5'd9, 5'd0, 32'd1, 32'd2);
      mem_reg_write = 1; mem_rd = 5'd3; mem_alu_result = 32'd10;
      wb_reg_write = 1; wb_rd = 5'd4; write_data_reg = 32'd30;
      cycle();
      check("fwd_result", alu_result, 32'd40);
      check("fwd_dest", {27'd0, dest_reg}, 32'd9);
      wb_rd = 5'd3; write_data_reg = 32'd20;
      cycle();
      check("fwd_mem_wins", alu_result, 32'd12);
      set_r(6'd33, 5'd0, 5'd0, 5'd9, 5'd0, 32'd5, 32'd6);
      mem_rd = 5'd0; wb_rd = 5'd0;
      cycle();
      check("fwd_r0", alu_result, 32'd11);
      clr_fwd();

      // signed overflow traps only on ADD
      set_r(6'd32, 5'd1, 5'd2, 5'd3, 5'd0, 32'h7FFFFFFF, 32'd1);
      cycle();
      check("ovf_add_flag", {31'd0, ovf_exception}, 32'd1);
      check("ovf_add_wb", {30'd0, wb_out}, 32'd0);
      check("ovf_add_res", alu_result, 32'h80000000);
      set_r(6'd33, 5'd1, 5'd2, 5'd3, 5'd0, 32'h7FFFFFFF, 32'd1);
      cycle();
      check("addu_no_trap", {31'd0, ovf_exception}, 32'd0);

      set_i(6'b000001, 16'hFFFF, 32'd5);
      cycle();
      check("addi_sext", alu_result, 32'd4);
      set_i(6'b000111, 16'hFFFF, 32'h12345678);
      cycle();
      check("andi_zext", alu_result, 32'h00005678);
      set_r(6'd3, 5'd0, 5'd2, 5'd3, 5'd4, 32'd0, 32'h80000000);
      cycle();
      check("sra", alu_result, 32'hF8000000);

      // multiply interlock
      set_r(6'd24, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFD, 32'd7);
      cycle();
      set_r(6'd18, 5'd0, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0);
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (!obs_stall) break;
         stalls++;
      end
      check("mult_stall_cycles", stalls, 32'd32);
      check("mflo", alu_result, 32'hFFFFFFEB);
      set_r(6'd16, 5'd0, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0);
      cycle();
      check("mfhi", alu_result, 32'hFFFFFFFF);

      // independent instruction flows while busy
      set_r(6'd25, 5'd1, 5'd2, 5'd0, 5'd0, 32'd123, 32'd456);
      cycle();
      set_r(6'd34, 5'd1, 5'd2, 5'd7, 5'd0, 32'd50, 32'd8);
      cycle();
      check("sub_no_stall", {31'd0, obs_stall}, 32'd0);
      check("sub_result", alu_result, 32'd42);
      nop();
      for (int i = 0; i < 33; i++) cycle();
      set_r(6'd18, 5'd0, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0);
      cycle();
      check("multu_lo", alu_result, 32'd56088);

      // reset aborts a multiply in flight
      set_r(6'd24, 5'd1, 5'd2, 5'd0, 5'd0, 32'd9, 32'd9);
      cycle();
      nop();
      for (int i = 0; i < 9; i++) cycle();
      set_r(6'd16, 5'd0, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0);
      rst_n = 0;
      cycle();
      check("rst_mid_stall", {31'd0, obs_stall}, 32'd0);
      check("rst_mid_wb", {30'd0, wb_out}, 32'd0);
      rst_n = 1;
      cycle();
      check("rst_mfhi_stall", {31'd0, obs_stall}, 32'd0);
      check("rst_mfhi", alu_result, 32'd0);

      // randomized traffic against the model
      for (int n = 0; n < 500; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         rst_n = ($urandom_range(0, 149) != 0);
         rs = 5'($urandom_range(0, 3));
         rt = 5'($urandom_range(0, 3));
         rd = 5'($urandom_range(0, 31));
         data_1 = $urandom;
         data_2 = $urandom;
         m = 3'($urandom);
         wb = 2'($urandom);
         mem_reg_write = 1'($urandom);
         mem_rd = 5'($urandom_range(0, 3));
         mem_alu_result = $urandom;
         wb_reg_write = 1'($urandom);
         wb_rd = 5'($urandom_range(0, 3));
         write_data_reg = $urandom;
         if (kind <= 5) begin
            ex = {1'b1, 4'b0010, 1'b0};
            imm = {16'd0, rd, 5'($urandom), functs[$urandom_range(0, 17)]};
         end else begin
            case (kind)
               6:       ex = {1'($urandom), 4'b0000, 1'($urandom)};
               7:       ex = {1'($urandom), 4'b0001, 1'($urandom)};
               8:       ex = {1'($urandom), 4'b0011, 1'($urandom)};
               default: ex = {1'($urandom), 4'($urandom_range(4, 15)), 1'($urandom)};
            endcase
            imm = {16'd0, 16'($urandom)};
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
